// File: rtl/dtcm_arb.sv
// rtl/dtcm_arb.sv - two-port arbiter/sequencer for the dtcm (read, full write, RMW partial write)
// Define DTCM_ARB_RR_EN for round-robin conflict resolution; default is fixed priority to port 0.
module dtcm_arb #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ0,
  input  logic            REQ1,
  input  logic            WE0,
  input  logic            WE1,
  input  logic [AW-1:0]   ADDR0,
  input  logic [AW-1:0]   ADDR1,
  input  logic [DW-1:0]   WDATA0,
  input  logic [DW-1:0]   WDATA1,
  input  logic [DW/8-1:0] BE0,
  input  logic [DW/8-1:0] BE1,
  output logic            GNT0,
  output logic            GNT1,
  output logic            RVALID0,
  output logic            RVALID1,
  output logic [DW-1:0]   RDATA0,
  output logic [DW-1:0]   RDATA1,
  output logic [AW-1:0]   M_WADDR,
  output logic [DW-1:0]   M_WDATA,
  output logic            M_WEN,
  output logic [AW-1:0]   M_RADDR,
  output logic            M_REN,
  input  logic [DW-1:0]   M_RDATA
);
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RMW_WR  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_own;
  logic            r_last;
  logic [AW-1:0]   r_laddr;
  logic [DW-1:0]   r_lwdata;
  logic [BW-1:0]   r_lbe;

  logic            w_sel;
  logic            w_grant;
  logic            w_we;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic [BW-1:0]   w_be;

  assign RDATA0 = M_RDATA;
  assign RDATA1 = M_RDATA;

  // w_sel is only meaningful when at least one REQ is high.
  always_comb begin
`ifdef DTCM_ARB_RR_EN
    w_sel = (REQ0 && REQ1) ? ~r_last : (REQ0 ? 1'b0 : (REQ1 ? 1'b1 : r_last));
`else
    w_sel = REQ0 ? 1'b0 : (REQ1 ? 1'b1 : r_last);
`endif
  end

  assign w_grant = (r_state == IDLE) && (REQ0 || REQ1);
  assign w_we    = w_sel ? WE1    : WE0;
  assign w_addr  = w_sel ? ADDR1  : ADDR0;
  assign w_wdata = w_sel ? WDATA1 : WDATA0;
  assign w_be    = w_sel ? BE1    : BE0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_own    <= 1'b0;
      r_last   <= 1'b1;
      r_laddr  <= '0;
      r_lwdata <= '0;
      r_lbe    <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_own    <= w_sel;
        r_last   <= w_sel;
        r_laddr  <= w_addr;
        r_lwdata <= w_wdata;
        r_lbe    <= w_be;
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    GNT0    = 1'b0;
    GNT1    = 1'b0;
    RVALID0 = 1'b0;
    RVALID1 = 1'b0;
    M_WADDR = '0;
    M_WDATA = '0;
    M_WEN   = 1'b0;
    M_RADDR = '0;
    M_REN   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          GNT0 = ~w_sel;
          GNT1 = w_sel;
          if (!w_we) begin
            M_REN   = 1'b1;
            M_RADDR = w_addr;
            w_next  = RD_WAIT;
          end else if (&w_be) begin
            M_WEN   = 1'b1;
            M_WADDR = w_addr;
            M_WDATA = w_wdata;
          end else if (|w_be) begin
            M_REN   = 1'b1;
            M_RADDR = w_addr;
            w_next  = RMW_WR;
          end
        end
      end
      RD_WAIT: begin
        RVALID0 = ~r_own;
        RVALID1 = r_own;
        w_next  = IDLE;
      end
      RMW_WR: begin
        M_WEN   = 1'b1;
        M_WADDR = r_laddr;
        // M_RDATA holds the old word fetched in the granting cycle.
        for (int i = 0; i < BW; i++) begin
          M_WDATA[8*i +: 8] = r_lbe[i] ? r_lwdata[8*i +: 8] : M_RDATA[8*i +: 8];
        end
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (RST) begin
      GNT0    = 1'b0;
      GNT1    = 1'b0;
      RVALID0 = 1'b0;
      RVALID1 = 1'b0;
      M_WEN   = 1'b0;
      M_REN   = 1'b0;
    end
  end
endmodule

// File: tb/tb_dtcm_arb.sv
// tb/tb_dtcm_arb.sv - directed self-checking bench for dtcm_arb with a behavioural dtcm
// Round-robin expectations apply when DTCM_ARB_RR_EN is defined.
module tb_dtcm_arb;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int BW = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic            REQ0, REQ1, WE0, WE1;
  logic [AW-1:0]   ADDR0, ADDR1;
  logic [DW-1:0]   WDATA0, WDATA1;
  logic [BW-1:0]   BE0, BE1;
  logic            GNT0, GNT1, RVALID0, RVALID1;
  logic [DW-1:0]   RDATA0, RDATA1;
  logic [AW-1:0]   M_WADDR, M_RADDR;
  logic [DW-1:0]   M_WDATA, M_RDATA;
  logic            M_WEN, M_REN;

  logic [DW-1:0]   mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  dtcm_arb #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .BE0(BE0), .BE1(BE1), .GNT0(GNT0), .GNT1(GNT1),
    .RVALID0(RVALID0), .RVALID1(RVALID1), .RDATA0(RDATA0), .RDATA1(RDATA1),
    .M_WADDR(M_WADDR), .M_WDATA(M_WDATA), .M_WEN(M_WEN),
    .M_RADDR(M_RADDR), .M_REN(M_REN), .M_RDATA(M_RDATA)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (M_WEN) mem[M_WADDR] <= M_WDATA;
    if (M_REN) M_RDATA <= mem[M_RADDR];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_full(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = a; WDATA0 = d; BE0 = 4'hF;
    #2;
    check_eq({tag, "_gnt0"}, GNT0, 1);
    check_eq({tag, "_wen"}, M_WEN, 1);
    check_eq({tag, "_wdata"}, M_WDATA, d);
    tick;
    REQ0 = 1'b0; WE0 = 1'b0;
  endtask

  task automatic rd0(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = a;
    #2;
    check_eq({tag, "_gnt0"}, GNT0, 1);
    check_eq({tag, "_ren"}, M_REN, 1);
    tick;
    REQ0 = 1'b0;
    #2;
    check_eq({tag, "_rvalid0"}, RVALID0, 1);
    check_eq({tag, "_rdata0"}, RDATA0, exp);
    check_eq({tag, "_nognt"}, GNT0, 0);
    tick;
  endtask

  initial begin
    logic exp1;
    RST = 1'b1;
    REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0;
    ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0; BE0 = '0; BE1 = '0;
    tick;
    tick;
    REQ0 = 1'b1;
    #2;
    check_eq("rst_gnt0", GNT0, 0);
    check_eq("rst_ren", M_REN, 0);
    check_eq("rst_rvalid0", RVALID0, 0);
    tick;
    REQ0 = 1'b0;
    RST = 1'b0;
    tick;

    // T1 full write and readback
    wr_full(4'd3, 32'hDEADBEEF, "t1_wr");
    check_eq("t1_waddr_latched", mem[3], 32'hDEADBEEF);
    rd0(4'd3, 32'hDEADBEEF, "t1_rd");

    // T2 read-modify-write from port 1
    wr_full(4'd5, 32'h11223344, "t2_pre");
    REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 4'd5; WDATA1 = 32'hAABBCCDD; BE1 = 4'b0101;
    #2;
    check_eq("t2_gnt1", GNT1, 1);
    check_eq("t2_ren", M_REN, 1);
    check_eq("t2_raddr", M_RADDR, 5);
    check_eq("t2_wen_idle", M_WEN, 0);
    tick;
    REQ1 = 1'b0; WE1 = 1'b0;
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 4'd5;
    #2;
    check_eq("t2_nognt0", GNT0, 0);
    check_eq("t2_nognt1", GNT1, 0);
    check_eq("t2_wen", M_WEN, 1);
    check_eq("t2_waddr", M_WADDR, 5);
    check_eq("t2_merge", M_WDATA, 32'h11BB33DD);
    tick;
    REQ0 = 1'b0;
    rd0(4'd5, 32'h11BB33DD, "t2_rd");

    // T3 conflict resolution, starting from reset so LAST=1
    RST = 1'b1;
    tick;
    RST = 1'b0;
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 4'd3;
    REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 4'd5;
    for (int k = 0; k < 4; k++) begin
`ifdef DTCM_ARB_RR_EN
      exp1 = (k % 2) == 1;
`else
      exp1 = 1'b0;
`endif
      #2;
      check_eq("t3_gnt0", GNT0, !exp1);
      check_eq("t3_gnt1", GNT1, exp1);
      tick;
      #2;
      check_eq("t3_wait_gnt", {GNT1, GNT0}, 0);
      check_eq("t3_rvalid", {RVALID1, RVALID0}, exp1 ? 2'b10 : 2'b01);
      check_eq("t3_rdata", M_RDATA, exp1 ? 32'h11BB33DD : 32'hDEADBEEF);
      tick;
    end
    REQ0 = 1'b0; REQ1 = 1'b0;

    // T4 write with no byte enables
    wr_full(4'd7, 32'h0000_1234, "t4_pre");
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 4'd7; WDATA0 = 32'hFFFF_FFFF; BE0 = 4'h0;
    #2;
    check_eq("t4_gnt0", GNT0, 1);
    check_eq("t4_wen", M_WEN, 0);
    check_eq("t4_ren", M_REN, 0);
    tick;
    REQ0 = 1'b0; WE0 = 1'b0;
    rd0(4'd7, 32'h0000_1234, "t4_rd");

    // T5 reset during RMW_WR discards the write
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 4'd7; WDATA0 = 32'h0000_00FF; BE0 = 4'b0001;
    #2;
    check_eq("t5_gnt0", GNT0, 1);
    check_eq("t5_ren", M_REN, 1);
    tick;
    REQ0 = 1'b0; WE0 = 1'b0;
    RST = 1'b1;
    #2;
    check_eq("t5_wen_rst", M_WEN, 0);
    tick;
    RST = 1'b0;
    rd0(4'd7, 32'h0000_1234, "t5_rd");

    // T6 back-to-back full writes over the whole address space
    REQ0 = 1'b1; WE0 = 1'b1; BE0 = 4'hF;
    for (int i = 0; i < 16; i++) begin
      ADDR0 = 4'(i); WDATA0 = 32'(i);
      #2;
      check_eq("t6_gnt0", GNT0, 1);
      check_eq("t6_waddr", M_WADDR, 32'(i));
      tick;
    end
    REQ0 = 1'b0; WE0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd0(4'(i), 32'(i), "t6_rd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
